// File: rtl/prog_delay_pkg.sv
// Shared constants and helpers for the programmable delay line.
package prog_delay_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_DEPTH = 90;
  localparam int DEF_DELAY     = 30;

  function automatic int calc_dly_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int calc_ptr_w(input int max_depth);
    return (max_depth > 1) ? $clog2(max_depth) : 1;
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned value,
                                              input int unsigned max_val);
    if (value == 0)
      return 1;
    else if (value > max_val)
      return max_val;
    else
      return value;
  endfunction

  // offset must be below depth; result is wr_ptr - offset modulo depth.
  function automatic int unsigned ptr_sub(input int unsigned wr_ptr,
                                          input int unsigned offset,
                                          input int unsigned depth);
    return (wr_ptr + depth - offset) % depth;
  endfunction

endpackage

// File: rtl/dl_sdp_ram.sv
// Simple dual-port sample store: synchronous write, combinational read.
module dl_sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 90,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line built on a circular buffer; behaves like a
// D-stage shift register advanced only on en, with output gated until filled.
module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter  int WIDTH         = DEF_WIDTH,
  parameter  int MAX_DEPTH     = DEF_MAX_DEPTH,
  parameter  int DEFAULT_DELAY = DEF_DELAY,
  localparam int DLY_W         = calc_dly_w(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             cfg_load,
  input  logic [DLY_W-1:0] cfg_delay,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [DLY_W-1:0] cur_delay,
  output logic             cfg_err
);

  localparam int PTR_W = calc_ptr_w(MAX_DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [DLY_W-1:0] r_fill;
  logic [DLY_W-1:0] r_cur_delay;
  logic [DLY_W-1:0] w_cfg_clamped;
  logic [DLY_W-1:0] w_dly_eff;
  logic [DLY_W-1:0] w_fill_base;
  logic [DLY_W-1:0] w_fill_nxt;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_rd_data;
  logic [WIDTH-1:0] w_tap;
  logic             r_dout_valid;
  logic             r_cfg_err;
  logic             w_cfg_oor;

  assign w_cfg_clamped = DLY_W'(clamp_delay(32'(cfg_delay), MAX_DEPTH));
  assign w_cfg_oor     = (w_cfg_clamped != cfg_delay);

  // A load on the same edge as en takes effect immediately: the accepted
  // sample counts as the first one of the new configuration.
  assign w_dly_eff   = cfg_load ? w_cfg_clamped : r_cur_delay;
  assign w_fill_base = cfg_load ? '0 : r_fill;
  assign w_fill_nxt  = (w_fill_base >= w_dly_eff) ? w_dly_eff
                                                  : w_fill_base + DLY_W'(1);

  assign w_rd_ptr     = PTR_W'(ptr_sub(32'(r_wr_ptr), 32'(w_dly_eff) - 32'd1, MAX_DEPTH));
  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(MAX_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);

  // D=1 reads the slot being written this edge, so bypass the buffer.
  assign w_tap = (w_dly_eff == DLY_W'(1)) ? din : w_rd_data;

  dl_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (en && rst_n),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (w_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_cur_delay  <= DLY_W'(DEFAULT_DELAY);
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= cfg_load && w_cfg_oor;
      if (cfg_load)
        r_cur_delay <= w_cfg_clamped;
      if (en) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_fill   <= w_fill_nxt;
        if (w_fill_nxt == w_dly_eff) begin
          r_dout       <= w_tap;
          r_dout_valid <= 1'b1;
        end else begin
          r_dout       <= '0;
          r_dout_valid <= 1'b0;
        end
      end else if (cfg_load) begin
        r_fill       <= '0;
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign cur_delay  = r_cur_delay;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed and randomized bench for prog_delay_line against a queue-based model.
module tb_prog_delay_line;

  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 90;
  localparam int DEF_DLY   = 30;
  localparam int DLY_W     = $clog2(MAX_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             cfg_load = 1'b0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [DLY_W-1:0] cur_delay;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted samples since the last reset/load, newest last.
  logic [WIDTH-1:0] hist[$];
  int               m_d     = DEF_DLY;
  logic [WIDTH-1:0] m_dout  = '0;
  logic             m_valid = 1'b0;
  logic             m_err   = 1'b0;

  prog_delay_line dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .cfg_load   (cfg_load),
    .cfg_delay  (cfg_delay),
    .dout       (dout),
    .dout_valid (dout_valid),
    .cur_delay  (cur_delay),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      hist.delete();
      m_d = DEF_DLY; m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_err = cfg_load && (cfg_delay == 0 || int'(cfg_delay) > MAX_DEPTH);
      if (cfg_load) begin
        hist.delete();
        m_d = (cfg_delay == 0) ? 1 : (int'(cfg_delay) > MAX_DEPTH) ? MAX_DEPTH : int'(cfg_delay);
        m_dout = '0; m_valid = 1'b0;
      end
      if (en) begin
        hist.push_back(din);
        if (hist.size() >= m_d) begin
          m_dout = hist[hist.size() - m_d];
          m_valid = 1'b1;
        end else begin
          m_dout = '0;
          m_valid = 1'b0;
        end
        while (hist.size() > MAX_DEPTH) void'(hist.pop_front());
      end
    end
  endtask

  // Drive one cycle's inputs, clock it, then compare every output to the model.
  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] d,
                      input logic ld, input logic [DLY_W-1:0] cd);
    @(negedge clk);
    rst_n = r; en = e; din = d; cfg_load = ld; cfg_delay = cd;
    @(posedge clk);
    model_edge();
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("cur_delay", 32'(cur_delay), 32'(m_d));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("reset_cur_delay", 32'(cur_delay), 32'd30);
    chk("reset_valid", 32'(dout_valid), 32'd0);

    // Default delay of 30 on a ramp
    for (int k = 1; k <= 31; k++) begin
      step(1'b1, 1'b1, WIDTH'(k), 1'b0, '0);
      if (k == 29) chk("d30_edge29_valid", 32'(dout_valid), 32'd0);
      if (k == 30) chk("d30_edge30_dout", 32'(dout), 32'd1);
      if (k == 31) chk("d30_edge31_dout", 32'(dout), 32'd2);
    end

    // Maximum depth across the pointer wrap
    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(90));
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, 1'b1, WIDTH'(k), 1'b0, '0);
      if (k == 89) chk("d90_edge89_valid", 32'(dout_valid), 32'd0);
      if (k == 90) chk("d90_edge90_dout", 32'(dout), 32'd1);
      if (k == 200) chk("d90_edge200_dout", 32'(dout), 32'd111);
    end

    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(45));
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b1, WIDTH'(k), 1'b0, '0);
      if (k == 45) chk("d45_edge45_dout", 32'(dout), 32'd1);
    end

    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(60));
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b1, WIDTH'(k), 1'b0, '0);
      if (k == 60) chk("d60_edge60_dout", 32'(dout), 32'd1);
    end

    // Mid-stream reset at D=60, then refill at default delay
    step(1'b0, 1'b1, 8'hEE, 1'b0, '0);
    chk("midreset_valid", 32'(dout_valid), 32'd0);
    chk("midreset_cur", 32'(cur_delay), 32'd30);
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b1, WIDTH'(k), 1'b0, '0);
      if (k == 30) chk("refill_edge30_dout", 32'(dout), 32'd1);
    end

    // D=4 with alternating enable
    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(4));
    for (int c = 1; c <= 10; c++) begin
      if (c % 2 == 1) step(1'b1, 1'b1, WIDTH'(10 + c / 2), 1'b0, '0);
      else            step(1'b1, 1'b0, 8'hFF, 1'b0, '0);
      if (c == 7) chk("d4_cycle7_dout", 32'(dout), 32'd10);
      if (c == 8) chk("d4_cycle8_hold", 32'(dout), 32'd10);
    end

    // Clamping and error pulse
    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(0));
    chk("clamp0_cur", 32'(cur_delay), 32'd1);
    chk("clamp0_err", 32'(cfg_err), 32'd1);
    idle();
    chk("clamp0_err_drop", 32'(cfg_err), 32'd0);
    step(1'b1, 1'b1, 8'h5A, 1'b0, '0);
    chk("d1_dout", 32'(dout), 32'h5A);
    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(127));
    chk("clamp127_cur", 32'(cur_delay), 32'd90);
    chk("clamp127_err", 32'(cfg_err), 32'd1);
    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(90));
    chk("load90_err", 32'(cfg_err), 32'd0);

    // Load with en on the same edge, then a flushing reload
    step(1'b1, 1'b1, 8'h33, 1'b1, DLY_W'(1));
    chk("load_en_dout", 32'(dout), 32'h33);
    chk("load_en_valid", 32'(dout_valid), 32'd1);
    step(1'b1, 1'b0, '0, 1'b1, DLY_W'(1));
    chk("reload_valid", 32'(dout_valid), 32'd0);

    // Randomized traffic with occasional reconfiguration and reset
    for (int n = 0; n < 3000; n++) begin
      logic r, e, ld;
      r  = ($urandom_range(0, 299) != 0);
      e  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 99) == 0);
      step(r, e, WIDTH'($urandom), ld,
           ($urandom_range(0, 3) == 0) ? DLY_W'($urandom_range(0, 127))
                                       : DLY_W'($urandom_range(1, 12)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
